commit_trace: RTL

COMMIT_TRACE -- requirements
Module: commit_trace

---
 rtl/commit_trace_pkg.sv | 24 ++
 rtl/commit_fifo.sv | 61 ++++++
 rtl/commit_trace.sv | 104 ++++++++++
 3 files changed

// File: rtl/commit_trace_pkg.sv
// Shared types and constants for the commit trace buffer.
// Holds the retire record layout, the ebreak encoding and the controller states.
package commit_trace_pkg;

  localparam int PC_W    = 64;
  localparam int INSTR_W = 32;

  localparam logic [INSTR_W-1:0] EBREAK = 32'h0010_0073;

  typedef struct packed {
    logic [PC_W-1:0]    pre_pc;
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } trace_rec_t;

  localparam int REC_W = $bits(trace_rec_t);

  typedef enum logic [1:0] {
    ST_RUN  = 2'd0,
    ST_HALT = 2'd1,
    ST_HANG = 2'd2
  } state_e;

endpackage

// File: rtl/commit_fifo.sv
// Power-of-two circular FIFO with occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module commit_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 160
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wptr_d  = do_push ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = do_pop  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage needs no reset; the count alone decides what is valid.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/commit_trace.sv
// Retire-trace buffer: queues commit records, counts retirements and
// watches for ebreak (halt) or a long commit-free stretch (hang).
module commit_trace
  import commit_trace_pkg::*;
#(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     regE_i_commit,
  input  logic [63:0]              regE_i_commit_pre_pc,
  input  logic [31:0]              regE_i_commit_instr,
  input  logic [63:0]              regE_i_commit_pc,
  input  logic                     trace_i_ready,
  output logic                     trace_o_valid,
  output logic [63:0]              trace_o_pre_pc,
  output logic [31:0]              trace_o_instr,
  output logic [63:0]              trace_o_pc,
  output logic [63:0]              trace_o_instret,
  output logic [$clog2(DEPTH):0]   trace_o_count,
  output logic                     trace_o_halt,
  output logic                     trace_o_timeout,
  output logic                     trace_o_overflow
);

  localparam int IDLE_W = $clog2(TIMEOUT + 1);

  state_e            state_q, state_d;
  logic [IDLE_W-1:0] idle_q, idle_d;
  logic [63:0]       instret_q, instret_d;
  logic              overflow_q, overflow_d;
  logic              accept, pop, fifo_full, fifo_empty, is_ebreak, idle_expired;
  trace_rec_t        wr_rec, head_rec;
  logic [REC_W-1:0]  head_raw;

  assign accept       = regE_i_commit && (state_q == ST_RUN);
  assign pop          = !fifo_empty && trace_i_ready;
  assign is_ebreak    = (regE_i_commit_instr == EBREAK);
  assign idle_expired = !regE_i_commit && (idle_q == IDLE_W'(TIMEOUT - 1));

  assign wr_rec = '{pre_pc: regE_i_commit_pre_pc,
                    instr:  regE_i_commit_instr,
                    pc:     regE_i_commit_pc};

  commit_fifo #(.DEPTH(DEPTH), .WIDTH(REC_W)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (accept),
    .pop_i   (pop),
    .wdata_i (wr_rec),
    .rdata_o (head_raw),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (trace_o_count)
  );

  always_ff @(posedge clk) begin
    if (!rst) state_q <= ST_RUN;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (state_q == ST_RUN) begin
      if (accept && is_ebreak) state_d = ST_HALT;
      else if (idle_expired)   state_d = ST_HANG;
    end
  end

  always_comb begin
    trace_o_halt    = (state_q == ST_HALT);
    trace_o_timeout = (state_q == ST_HANG);
  end

  always_comb begin
    instret_d  = accept ? instret_q + 64'd1 : instret_q;
    overflow_d = overflow_q | (accept && fifo_full && !pop);
    idle_d     = idle_q;
    if (state_q == ST_RUN) idle_d = regE_i_commit ? '0 : idle_q + IDLE_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      instret_q  <= '0;
      overflow_q <= 1'b0;
      idle_q     <= '0;
    end else begin
      instret_q  <= instret_d;
      overflow_q <= overflow_d;
      idle_q     <= idle_d;
    end
  end

  // Fields are masked while empty so stale storage never leaks out.
  assign head_rec         = trace_rec_t'(head_raw);
  assign trace_o_valid    = !fifo_empty;
  assign trace_o_pre_pc   = trace_o_valid ? head_rec.pre_pc : '0;
  assign trace_o_instr    = trace_o_valid ? head_rec.instr  : '0;
  assign trace_o_pc       = trace_o_valid ? head_rec.pc     : '0;
  assign trace_o_instret  = instret_q;
  assign trace_o_overflow = overflow_q;

endmodule
